expr_eval: RTL and testbench
============================

Name: expr_eval

Overview:
- Streaming ASCII arithmetic-expression recogniser and evaluator; parametrised successor to the single-digit expression checker.
- Consumes one character per accepted cycle and tracks the grammar `expr = num (op num)*`.
- Operands are multi-digit decimal numbers; `*` binds tighter than `+`.
- Continuously reports whether the prefix received since the last clear is a complete valid expression, and its value modulo 2^WIDTH.

Parameters:
- WIDTH, 16: bit width of all arithmetic registers and of `value`; all arithmetic wraps mod 2^WIDTH.
- MAX_DIGITS, 4: maximum digit count of a single operand; a longer operand is an error.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-high reset; also the stream-restart control.
- in  input  8  ASCII character.
- in_valid  input  1  `in` is consumed on a rising clk edge when high.
- out  output  1  high when the consumed prefix is a valid complete expression.
- value  output  WIDTH  value of the consumed prefix; meaningful only when `out`=1, else forced 0.
- err  output  1  sticky syntax error since the last clr.

Behaviour:
- Reset: `clr`=1 asynchronously forces state IDLE and all registers to their reset values.
  - Reset values: sum=0, prod=1, cur=0, ndig=0.
  - Outputs during/after reset: out=0, value=0, err=0.
  - While `clr`=1, input is ignored, including on an edge where `clr` and `in_valid` are both high.
- Character classes:
  - digit: 8'd48..8'd57, d = in-48.
  - plus: 8'd43.
  - star: 8'd42.
  - Every other code is illegal.
- States: IDLE (nothing received), NUM (inside an operand), OP (operator just received), ERR (sticky).
- Transitions, taken only when in_valid=1:
  - IDLE: digit -> NUM; any other character -> ERR.
  - NUM: digit -> NUM if ndig<MAX_DIGITS, else ERR.
  - NUM: plus or star -> OP.
  - NUM: illegal character -> ERR.
  - OP: digit -> NUM; plus, star or illegal -> ERR.
  - ERR: stays in ERR until clr.
- Datapath updates (all mod 2^WIDTH):
  - digit: cur <= cur*10+d; ndig <= ndig+1.
  - star: prod <= prod*cur; cur <= 0; ndig <= 0.
  - plus: sum <= sum + prod*cur; prod <= 1; cur <= 0; ndig <= 0.
  - ERR: registers frozen.
- Outputs, combinational from registered state; zero additional latency after the sampling edge:
  - out = (state==NUM).
  - value = out ? sum + prod*cur : 0.
  - err = (state==ERR).
- in_valid=0: all state holds; outputs are unchanged.
- Leading zeros are legal ("007" = 7); a digit count of exactly MAX_DIGITS is legal.
- Overflow is not an error; wrap silently.
- Multiplier width: WIDTH x WIDTH, truncated to WIDTH.

Optional Feature:
- Macro: EXPR_SUB_EN.
- Defined:
  - `-` (8'd45) is a legal operator with the same precedence as `+` and the same transition rules as plus.
  - Add register neg (reset 0).
  - On plus/minus: sum <= sum + (neg ? -(prod*cur) : prod*cur); neg <= (in==45).
  - value = sum + (neg ? -(prod*cur) : prod*cur).
  - Results are two's complement mod 2^WIDTH.
- Undefined: 8'd45 is illegal, giving ERR from any state; the neg register is absent.

Test Plan:
- clr pulse, then "1+2*3" one char/cycle, in_valid=1:
  - out after each char = 1,0,1,0,1.
  - Final value = 7, err = 0.
- "12*34+5":
  - value after "12*34" = 408.
  - Final value = 413, out = 1.
- "0*9**":
  - out=1 after "0*9" with value 0.
  - err=1 from 5th char onward.
  - Further "9" leaves out=0 and err=1.
  - clr asserted with in="9": no consume; then "9" gives out=1, value=9.
- WIDTH=8: "20*13" -> value = 4 (260 mod 256), err=0.
- MAX_DIGITS=4: "1234" -> out=1, value=1234; a 5th "5" -> err=1.
- in_valid toggles low between chars of "3*4": result identical (12).
- EXPR_SUB_EN defined:
  - "9-2*3" -> 3.
  - "2-5" -> 16'hFFFD.
- EXPR_SUB_EN undefined: "2-" -> err=1.

Source files
------------

// File: rtl/expr_eval.sv
// Streaming ASCII evaluator for expr = num (op num)*, '*' binding tighter than '+'.
// Optional `-` operator enabled by defining EXPR_SUB_EN.
module expr_eval #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             out,
  output logic [WIDTH-1:0] value,
  output logic             err
);

  localparam int NW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {IDLE, NUM, OP, ERR} state_t;

  state_t           state;
  logic [WIDTH-1:0] sum, prod, cur;
  logic [NW-1:0]    ndig;

  logic             is_digit, is_plus, is_star, is_minus, is_addop;
  logic [WIDTH-1:0] cur_next, pc, term;

  assign is_digit = (in >= 8'd48) && (in <= 8'd57);
  assign is_plus  = (in == 8'd43);
  assign is_star  = (in == 8'd42);

`ifdef EXPR_SUB_EN
  logic neg;
  assign is_minus = (in == 8'd45);
  assign term     = neg ? -pc : pc;
`else
  assign is_minus = 1'b0;
  assign term     = pc;
`endif

  assign is_addop = is_plus | is_minus;
  // For ASCII '0'..'9' the low nibble is already the digit value.
  assign cur_next = cur * WIDTH'(10) + WIDTH'(in[3:0]);
  assign pc       = prod * cur;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      sum   <= '0;
      prod  <= WIDTH'(1);
      cur   <= '0;
      ndig  <= '0;
`ifdef EXPR_SUB_EN
      neg   <= 1'b0;
`endif
    end else if (in_valid) begin
      unique case (state)
        IDLE, OP: begin
          if (is_digit) begin
            state <= NUM;
            cur   <= cur_next;
            ndig  <= ndig + NW'(1);
          end else begin
            state <= ERR;
          end
        end
        NUM: begin
          if (is_digit) begin
            if (ndig < NW'(MAX_DIGITS)) begin
              cur  <= cur_next;
              ndig <= ndig + NW'(1);
            end else begin
              state <= ERR;
            end
          end else if (is_star) begin
            state <= OP;
            prod  <= pc;
            cur   <= '0;
            ndig  <= '0;
          end else if (is_addop) begin
            state <= OP;
            sum   <= sum + term;
            prod  <= WIDTH'(1);
            cur   <= '0;
            ndig  <= '0;
`ifdef EXPR_SUB_EN
            neg   <= is_minus;
`endif
          end else begin
            state <= ERR;
          end
        end
        ERR: state <= ERR;
      endcase
    end
  end

  assign out   = (state == NUM);
  assign err   = (state == ERR);
  assign value = out ? sum + term : '0;

endmodule

// File: tb/tb_expr_eval.sv
// Directed-vector bench for expr_eval: a 16-bit instance plus an 8-bit one sharing the stimulus.
module tb_expr_eval;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  in = 8'h20;
  logic        in_valid = 1'b0;
  logic        out, err, out8, err8;
  logic [15:0] value;
  logic [7:0]  value8;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  expr_eval #(.WIDTH(16), .MAX_DIGITS(4)) dut (
    .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
    .out(out), .value(value), .err(err)
  );

  expr_eval #(.WIDTH(8), .MAX_DIGITS(4)) dut8 (
    .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
    .out(out8), .value(value8), .err(err8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    in       = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    do_clr();
    #1;
    chk("reset_out",   {31'd0, out}, 32'd0);
    chk("reset_value", {16'd0, value}, 32'd0);
    chk("reset_err",   {31'd0, err}, 32'd0);

    // "1+2*3"
    send("1"); chk("e1_out1", {31'd0, out}, 32'd1); chk("e1_val1", {16'd0, value}, 32'd1);
    send("+"); chk("e1_out2", {31'd0, out}, 32'd0); chk("e1_val2", {16'd0, value}, 32'd0);
    send("2"); chk("e1_out3", {31'd0, out}, 32'd1); chk("e1_val3", {16'd0, value}, 32'd3);
    send("*"); chk("e1_out4", {31'd0, out}, 32'd0);
    send("3"); chk("e1_out5", {31'd0, out}, 32'd1);
    chk("e1_value", {16'd0, value}, 32'd7);
    chk("e1_err",   {31'd0, err}, 32'd0);

    // "12*34+5"
    do_clr();
    send_str("12*34");
    chk("e2_val408", {16'd0, value}, 32'd408);
    chk("e2_w8_152", {24'd0, value8}, 32'd152);
    send("+");  chk("e2_out_op", {31'd0, out}, 32'd0);
    send("5");
    chk("e2_val413", {16'd0, value}, 32'd413);
    chk("e2_out",    {31'd0, out}, 32'd1);

    // "0*9**" then recovery through clr
    do_clr();
    send_str("0*9");
    chk("e3_out",   {31'd0, out}, 32'd1);
    chk("e3_val0",  {16'd0, value}, 32'd0);
    send("*"); chk("e3_err4", {31'd0, err}, 32'd0);
    send("*"); chk("e3_err5", {31'd0, err}, 32'd1); chk("e3_out5", {31'd0, out}, 32'd0);
    send("9");
    chk("e3_sticky_err", {31'd0, err}, 32'd1);
    chk("e3_sticky_out", {31'd0, out}, 32'd0);
    chk("e3_sticky_val", {16'd0, value}, 32'd0);
    @(negedge clk);
    clr = 1'b1; in = "9"; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("clr_ign_out", {31'd0, out}, 32'd0);
    chk("clr_ign_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    idle(1);
    chk("clr_idle_out", {31'd0, out}, 32'd0);
    send("9");
    chk("after_clr_out", {31'd0, out}, 32'd1);
    chk("after_clr_val", {16'd0, value}, 32'd9);

    // Wrap in the 8-bit instance: 260 mod 256
    do_clr();
    send_str("20*13");
    chk("w8_value", {24'd0, value8}, 32'd4);
    chk("w8_err",   {31'd0, err8}, 32'd0);
    chk("w16_value", {16'd0, value}, 32'd260);

    // Digit-count boundary
    do_clr();
    send_str("1234");
    chk("d4_out", {31'd0, out}, 32'd1);
    chk("d4_val", {16'd0, value}, 32'd1234);
    send("5");
    chk("d5_err", {31'd0, err}, 32'd1);
    chk("d5_out", {31'd0, out}, 32'd0);

    // Leading zeros
    do_clr();
    send_str("007");
    chk("lz_val", {16'd0, value}, 32'd7);

    // in_valid gaps between characters of "3*4"
    do_clr();
    send("3"); idle(3);
    chk("gap_hold_out", {31'd0, out}, 32'd1);
    chk("gap_hold_val", {16'd0, value}, 32'd3);
    send("*"); idle(2);
    chk("gap_hold_op", {31'd0, out}, 32'd0);
    send("4"); idle(2);
    chk("gap_val12", {16'd0, value}, 32'd12);
    chk("gap_err",   {31'd0, err}, 32'd0);

    // Illegal first characters
    do_clr();
    send("+");
    chk("lead_plus_err", {31'd0, err}, 32'd1);
    do_clr();
    send_str("4a");
    chk("illegal_err", {31'd0, err}, 32'd1);

`ifdef EXPR_SUB_EN
    do_clr();
    send_str("9-2*3");
    chk("sub_val3", {16'd0, value}, 32'd3);
    chk("sub_out",  {31'd0, out}, 32'd1);
    do_clr();
    send_str("2-5");
    chk("sub_neg", {16'd0, value}, 32'h0000FFFD);
    chk("sub_neg_err", {31'd0, err}, 32'd0);
`else
    do_clr();
    send_str("2-");
    chk("minus_err", {31'd0, err}, 32'd1);
    chk("minus_out", {31'd0, out}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
